// File: rtl/pipes_pkg.sv
// Shared pipeline types and constants for the decode-stage register scoreboard.
package pipes;

  localparam int unsigned SCB_NREG         = 32;
  localparam int unsigned SCB_CNT_W        = 2;
  localparam int unsigned SCB_MAX_INFLIGHT = 4;

  typedef logic [4:0]           creg_addr_t;
  typedef logic [SCB_CNT_W-1:0] scb_cnt_t;

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// scb_counter: per-register pending-write counter with clear, inc, dec and a nonzero flag.
module scb_counter
  import pipes::*;
#(
  parameter int unsigned W = SCB_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         nz
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Simultaneous inc and dec cancel; clear wins over both.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign nz  = (cnt_q != '0);

  a_no_wrap: assert property (@(posedge clk) disable iff (!reset)
    !clr |-> !((inc && !dec && cnt_q == '1) || (dec && !inc && cnt_q == '0)));

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage register scoreboard: pending-write tracking, stall flags and issue throttling.
// Define WB_BYPASS_EN to release stalls (and issue credit) in the writeback cycle itself.
module hazard_scoreboard
  import pipes::*;
#(
  parameter int unsigned NREG         = SCB_NREG,
  parameter int unsigned CNT_W        = SCB_CNT_W,
  parameter int unsigned MAX_INFLIGHT = SCB_MAX_INFLIGHT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [4:0]                        rs1,
  input  logic [4:0]                        rs2,
  input  logic                              iss_valid,
  input  logic                              iss_wen,
  input  logic [4:0]                        iss_rd,
  output logic                              iss_ready,
  input  logic                              wb_valid,
  input  logic [4:0]                        wb_rd,
  input  logic                              flush,
  output logic                              bubble1,
  output logic                              bubble2,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              wb_err
);

  localparam int unsigned INFL_W = $clog2(MAX_INFLIGHT + 1);

  creg_addr_t        a_rs1, a_rs2, a_iss, a_wb;
  logic [CNT_W-1:0]  cnt [NREG];
  logic [NREG-1:0]   nz;
  logic [NREG-1:0]   inc_v, dec_v;
  logic              acc, ret;
  logic [INFL_W-1:0] infl_eff;
  logic [INFL_W-1:0] inflight_q, inflight_d;
  logic              wb_err_q, wb_err_d;

  assign a_rs1 = rs1;
  assign a_rs2 = rs2;
  assign a_iss = iss_rd;
  assign a_wb  = wb_rd;

  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    scb_counter #(.W(CNT_W)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (flush),
      .inc  (inc_v[r]),
      .dec  (dec_v[r]),
      .cnt  (cnt[r]),
      .nz   (nz[r])
    );
  end

  always_comb begin
    ret      = wb_valid && (a_wb != '0) && nz[a_wb];
    infl_eff = inflight_q;
`ifdef WB_BYPASS_EN
    infl_eff = inflight_q - INFL_W'(ret);
`endif
    iss_ready = !(iss_wen && (a_iss != '0) &&
                  ((cnt[a_iss] == '1) || (infl_eff == INFL_W'(MAX_INFLIGHT))));
    acc       = iss_valid && iss_ready && iss_wen && (a_iss != '0);

    inc_v = '0;
    dec_v = '0;
    inc_v[a_iss] = acc;
    dec_v[a_wb]  = ret;

    wb_err_d   = wb_err_q || (wb_valid && (a_wb != '0) && !nz[a_wb]);
    inflight_d = flush ? '0 : (inflight_q + INFL_W'(acc) - INFL_W'(ret));

    bubble1 = (a_rs1 != '0) && nz[a_rs1];
    bubble2 = (a_rs2 != '0) && nz[a_rs2];
`ifdef WB_BYPASS_EN
    // The retiring value is forwarded, so its last pending write no longer stalls.
    if (wb_valid && (a_wb == a_rs1) && (cnt[a_rs1] == CNT_W'(1))) bubble1 = 1'b0;
    if (wb_valid && (a_wb == a_rs2) && (cnt[a_rs2] == CNT_W'(1))) bubble2 = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign inflight = inflight_q;
  assign wb_err   = wb_err_q;

  a_inflight_bound: assert property (@(posedge clk) disable iff (!reset)
    inflight_q <= INFL_W'(MAX_INFLIGHT));

endmodule
